// File: rtl/matrix_uart_printer_pkg.sv
// Shared formatting constants, FSM state types and ASCII helpers for the
// matrix result printer.
package matrix_fmt_pkg;

  localparam int unsigned HDR_LEN = 41;
  localparam int unsigned ROW_LEN = 32;
  localparam int unsigned MSG_LEN = HDR_LEN + 4 * ROW_LEN;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LBRK  = 8'h5B;
  localparam logic [7:0] CH_RBRK  = 8'h5D;

  // Header text, first character in the most significant byte.
  localparam logic [8*HDR_LEN-1:0] HDR_STR =
    {CH_CR, CH_LF, "The matrix multiplication result is: ", CH_CR, CH_LF};

  typedef enum logic [1:0] {T_IDLE, T_HDR, T_ROW, T_FIN} top_state_t;
  typedef enum logic [2:0] {B_IDLE, B_LOAD, B_WSTART, B_WEND, B_NEXT} byte_state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    return 8'h37 + {4'h0, nibble};
  endfunction

  function automatic logic [7:0] hdr_char(input logic [5:0] idx);
    logic [8:0] bitpos;
    bitpos = 9'((HDR_LEN - 1 - 32'(idx)) * 8);
    return HDR_STR[bitpos +: 8];
  endfunction

endpackage

// File: rtl/matrix_uart_printer_byte_sender.sv
// One-byte handshake with the uart transmitter: strobe the byte, wait for the
// frame to start and finish, then report completion for one cycle.
module uart_byte_sender
  import matrix_fmt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] byte_in,
  output logic       ack,
  output logic       transmit,
  output logic [7:0] tx_byte,
  input  logic       is_transmitting
);

  byte_state_t state;

  // Byte handshake FSM; a new request is taken from IDLE or straight out of NEXT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= B_IDLE;
      ack      <= 1'b0;
      transmit <= 1'b0;
      tx_byte  <= '0;
    end else begin
      ack      <= 1'b0;
      transmit <= 1'b0;
      unique case (state)
        B_IDLE, B_NEXT: begin
          if (req) begin
            state    <= B_LOAD;
            transmit <= 1'b1;
            tx_byte  <= byte_in;
          end else begin
            state <= B_IDLE;
          end
        end
        B_LOAD:   state <= B_WSTART;
        B_WSTART: if (is_transmitting) state <= B_WEND;
        B_WEND: begin
          if (!is_transmitting) begin
            state <= B_NEXT;
            ack   <= 1'b1;
          end
        end
        default:  state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/matrix_uart_printer.sv
// Holds the 4x4 result matrix and streams it as an ASCII report through the
// uart byte sender.
module matrix_uart_printer
  import matrix_fmt_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned VAL_W    = 18
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             c_we,
  input  logic [3:0]       c_idx,
  input  logic [VAL_W-1:0] c_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             transmit,
  output logic [7:0]       tx_byte,
  input  logic             is_transmitting
);

  logic [VAL_W-1:0] mem [NUM_ROWS*NUM_ROWS];
  top_state_t       state;
  logic [5:0]       hidx;
  logic [1:0]       row;
  logic [1:0]       col;
  logic [4:0]       pos;
  logic [2:0]       dig;
  logic             last;
  logic             ack;
  logic             req;
  logic             accept;
  logic [7:0]       cur_byte;
  logic [VAL_W-1:0] cur_val;
  logic [3:0]       nib;

  // Counters always point at the next byte to hand over, so the byte is ready
  // in the same cycle the sender reports completion of the previous one.
  assign accept = start && !busy;
  assign req    = accept || ((state == T_HDR || state == T_ROW) && ack && !last);

  // Character generator for the byte the counters currently point at.
  always_comb begin
    cur_byte = 8'h00;
    cur_val  = mem[{row, col}];
    unique case (dig)
      3'd0:    nib = {2'b00, cur_val[17:16]};
      3'd1:    nib = cur_val[15:12];
      3'd2:    nib = cur_val[11:8];
      3'd3:    nib = cur_val[7:4];
      default: nib = cur_val[3:0];
    endcase
    if (state == T_ROW) begin
      if (pos == 5'd0)       cur_byte = CH_LBRK;
      else if (pos == 5'd1)  cur_byte = CH_SPACE;
      else if (pos <= 5'd27) begin
        if (dig < 3'd5)       cur_byte = hex_ascii(nib);
        else if (dig == 3'd5) cur_byte = CH_COMMA;
        else                  cur_byte = CH_SPACE;
      end
      else if (pos == 5'd28) cur_byte = CH_SPACE;
      else if (pos == 5'd29) cur_byte = CH_RBRK;
      else if (pos == 5'd30) cur_byte = CH_CR;
      else                   cur_byte = CH_LF;
    end else begin
      cur_byte = hdr_char(hidx);
    end
  end

  // Result buffer and report sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hidx  <= '0;
      row   <= '0;
      col   <= '0;
      pos   <= '0;
      dig   <= '0;
      last  <= 1'b0;
      for (int unsigned i = 0; i < NUM_ROWS*NUM_ROWS; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      if (c_we && !busy) mem[c_idx] <= c_data;
      unique case (state)
        T_IDLE, T_FIN: begin
          if (accept) begin
            state <= T_HDR;
            busy  <= 1'b1;
            hidx  <= 6'd1;
          end else begin
            state <= T_IDLE;
          end
        end
        T_HDR: begin
          if (req) begin
            if (hidx == 6'(HDR_LEN - 1)) begin
              state <= T_ROW;
              hidx  <= '0;
            end else begin
              hidx <= hidx + 6'd1;
            end
          end
        end
        T_ROW: begin
          if (ack && last) begin
            state <= T_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            last  <= 1'b0;
            row   <= '0;
          end else if (req) begin
            if (pos == 5'(ROW_LEN - 1)) begin
              pos <= '0;
              col <= '0;
              dig <= '0;
              if (row == 2'(NUM_ROWS - 1)) last <= 1'b1;
              else                         row  <= row + 2'd1;
            end else begin
              pos <= pos + 5'd1;
              // Digit slots 0..4 plus the ", " separator form one 7-byte column.
              if (pos >= 5'd2 && pos <= 5'd27) begin
                if (dig == 3'd6) begin
                  dig <= '0;
                  col <= col + 2'd1;
                end else begin
                  dig <= dig + 3'd1;
                end
              end
            end
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

  uart_byte_sender u_sender (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .byte_in         (cur_byte),
    .ack             (ack),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting)
  );

endmodule
